// File: rtl/instr_encoder.sv
// Instruction encoder and loader: turns decoded instruction fields into
// 32-bit MIPS-style words and writes them into consecutive instruction-memory
// words over one load session (start .. finish).
module instr_encoder #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic          finish_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [2:0]    kind_i,
    input  logic [2:0]    alufunc_i,
    input  logic [4:0]    rs_i,
    input  logic [4:0]    rt_i,
    input  logic [4:0]    rd_i,
    input  logic [15:0]   imm_i,
    input  logic [25:0]   target_i,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_addr_o,
    output logic [31:0]   imem_wdata_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          err_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_ADDR  = AW'(1);
    localparam logic [AW:0]   ONE_CNT   = (AW + 1)'(1);

    // Instruction kind codes
    localparam logic [2:0] K_RTYPE = 3'd0;
    localparam logic [2:0] K_LW    = 3'd1;
    localparam logic [2:0] K_SW    = 3'd2;
    localparam logic [2:0] K_BEQ   = 3'd3;
    localparam logic [2:0] K_ADDI  = 3'd4;
    localparam logic [2:0] K_J     = 3'd5;

    // Map an ALU-control code to its RTYPE funct field; bit 6 flags a legal code.
    function automatic logic [6:0] rtype_funct(input logic [2:0] alufunc);
        logic [6:0] res;
        case (alufunc)
            3'b010:  res = {1'b1, 6'b100000};  // add
            3'b110:  res = {1'b1, 6'b100010};  // sub
            3'b000:  res = {1'b1, 6'b100100};  // and
            3'b001:  res = {1'b1, 6'b100101};  // or
            3'b111:  res = {1'b1, 6'b101010};  // slt
            default: res = {1'b0, 6'b000000};
        endcase
        return res;
    endfunction

    // Build the encoded word; bit 32 flags a legal instruction.
    function automatic logic [32:0] encode(
        input logic [2:0]  kind,
        input logic [2:0]  alufunc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [32:0] res;
        logic [6:0]  fn;
        fn = rtype_funct(alufunc);
        case (kind)
            K_RTYPE: res = {fn[6], 6'b000000, rs, rt, rd, 5'b00000, fn[5:0]};
            K_LW:    res = {1'b1, 6'b100011, rs, rt, imm};
            K_SW:    res = {1'b1, 6'b101011, rs, rt, imm};
            K_BEQ:   res = {1'b1, 6'b000100, rs, rt, imm};
            K_ADDI:  res = {1'b1, 6'b001000, rs, rt, imm};
            K_J:     res = {1'b1, 6'b000010, target};
            default: res = {1'b0, 32'h0000_0000};
        endcase
        return res;
    endfunction

    state_t        state_r;
    state_t        state_nx_s;
    logic [AW-1:0] addr_r;
    logic [AW:0]   count_r;
    logic          we_r;
    logic [AW-1:0] waddr_r;
    logic [31:0]   wdata_r;
    logic          err_r;
    logic          done_r;

    logic          ready_s;
    logic          xfer_s;
    logic [32:0]   enc_s;
    logic          wr_s;
    logic          bad_s;
    logic          end_s;

    // Handshake and transfer classification for the current cycle.
    always_comb begin
        ready_s = (state_r == ST_LOAD) && !start_i && !finish_i;
        xfer_s  = valid_i && ready_s;
        enc_s   = encode(kind_i, alufunc_i, rs_i, rt_i, rd_i, imm_i, target_i);
        wr_s    = xfer_s && enc_s[32];
        bad_s   = xfer_s && !enc_s[32];
        end_s   = finish_i && !start_i && (state_r != ST_IDLE);
    end

    // Next-state logic: start beats finish beats a transfer.
    always_comb begin
        state_nx_s = state_r;
        if (start_i) begin
            state_nx_s = ST_LOAD;
        end else if (end_s) begin
            state_nx_s = ST_IDLE;
        end else if (wr_s) begin
            if (addr_r == LAST_ADDR) begin
                state_nx_s = ST_FULL;
            end else begin
                state_nx_s = ST_LOAD;
            end
        end else if (bad_s) begin
            state_nx_s = ST_ERROR;
        end else begin
            state_nx_s = state_r;
        end
    end

    // State register and one-cycle strobes (write enable, session-end pulse).
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            we_r    <= wr_s;
            done_r  <= end_s;
        end
    end

    // Session write pointer, word count and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            addr_r  <= {AW{1'b0}};
            count_r <= {(AW + 1){1'b0}};
            err_r   <= 1'b0;
        end else if (start_i) begin
            addr_r  <= {AW{1'b0}};
            count_r <= {(AW + 1){1'b0}};
            err_r   <= 1'b0;
        end else if (wr_s) begin
            addr_r  <= addr_r + ONE_ADDR;  // wraps to 0 after the last word
            count_r <= count_r + ONE_CNT;
        end else if (bad_s) begin
            err_r   <= 1'b1;
        end else begin
            addr_r  <= addr_r;
            count_r <= count_r;
        end
    end

    // Memory write port: address/data captured on a write, held otherwise.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            waddr_r <= {AW{1'b0}};
            wdata_r <= 32'h0000_0000;
        end else if (wr_s) begin
            waddr_r <= addr_r;
            wdata_r <= enc_s[31:0];
        end else begin
            waddr_r <= waddr_r;
            wdata_r <= wdata_r;
        end
    end

    assign ready_o      = ready_s;
    assign imem_we_o    = we_r;
    assign imem_addr_o  = waddr_r;
    assign imem_wdata_o = wdata_r;
    assign count_o      = count_r;
    assign full_o       = (state_r == ST_FULL);
    assign err_o        = err_r;
    assign done_o       = done_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4): directed vectors followed by
// randomized traffic compared against a behavioural session model.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_FULL = 2;
    localparam int PH_ERR  = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          finish;
    logic          valid;
    logic          ready;
    logic [2:0]    kind;
    logic [2:0]    alufunc;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err;
    logic          done;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Behavioural model of the load session.
    int        m_phase = PH_IDLE;
    int        m_addr  = 0;
    int        m_cnt   = 0;
    bit        m_err   = 1'b0;
    bit        m_we    = 1'b0;
    int        m_waddr = 0;
    bit [31:0] m_wdata = 32'h0;
    bit        m_done  = 1'b0;

    instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .finish_i     (finish),
        .valid_i      (valid),
        .ready_o      (ready),
        .kind_i       (kind),
        .alufunc_i    (alufunc),
        .rs_i         (rs),
        .rt_i         (rt),
        .rd_i         (rd),
        .imm_i        (imm),
        .target_i     (target),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .count_o      (count),
        .full_o       (full),
        .err_o        (err),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference encoding from the instruction-format tables; bit 32 = legal.
    function automatic bit [32:0] ref_encode(input int k, input int af, input int s, input int t,
                                             input int d, input int im, input int tg);
        longint w;
        int     fn;
        bit     ok;
        int     ops[6];
        ops = '{0, 35, 43, 4, 8, 2};
        ok = 1'b1;
        w  = 0;
        if (k == 0) begin
            fn = -1;
            if (af == 2) fn = 32;
            if (af == 6) fn = 34;
            if (af == 0) fn = 36;
            if (af == 1) fn = 37;
            if (af == 7) fn = 42;
            if (fn < 0) ok = 1'b0;
            else w = s * 64'd2097152 + t * 64'd65536 + d * 64'd2048 + fn;
        end else if (k >= 1 && k <= 4) begin
            w = ops[k] * 64'd67108864 + s * 64'd2097152 + t * 64'd65536 + im;
        end else if (k == 5) begin
            w = ops[5] * 64'd67108864 + tg;
        end else begin
            ok = 1'b0;
        end
        return {ok, w[31:0]};
    endfunction

    // Advance the model by one clock edge using the inputs presented.
    task automatic model_edge();
        bit [32:0] e;
        if (!rst_n) begin
            m_phase = PH_IDLE; m_addr = 0; m_cnt = 0; m_err = 1'b0;
            m_we = 1'b0; m_waddr = 0; m_wdata = 32'h0; m_done = 1'b0;
        end else begin
            m_we   = 1'b0;
            m_done = 1'b0;
            if (start) begin
                m_phase = PH_LOAD; m_addr = 0; m_cnt = 0; m_err = 1'b0;
            end else if (finish && m_phase != PH_IDLE) begin
                m_phase = PH_IDLE; m_done = 1'b1;
            end else if (valid && m_phase == PH_LOAD) begin
                e = ref_encode(kind, alufunc, rs, rt, rd, imm, target);
                if (e[32]) begin
                    m_we = 1'b1; m_waddr = m_addr; m_wdata = e[31:0];
                    m_cnt++;
                    m_addr = (m_addr + 1) % DEPTH;
                    if (m_cnt == DEPTH) m_phase = PH_FULL;
                end else begin
                    m_phase = PH_ERR; m_err = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive inputs, check ready, take the edge, check registered outputs.
    task automatic step(input bit r, input bit st, input bit fi, input bit va, input int k,
                        input int af, input int s, input int t, input int d, input int im,
                        input int tg);
        bit exp_ready;
        rst_n = r; start = st; finish = fi; valid = va;
        kind = 3'(k); alufunc = 3'(af); rs = 5'(s); rt = 5'(t); rd = 5'(d);
        imm = 16'(im); target = 26'(tg);
        #1;
        exp_ready = (m_phase == PH_LOAD) && !st && !fi;
        check_eq("ready", 64'(ready), 64'(exp_ready));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("we", 64'(imem_we), 64'(m_we));
        check_eq("addr", 64'(imem_addr), 64'(m_waddr));
        check_eq("wdata", 64'(imem_wdata), 64'(m_wdata));
        check_eq("count", 64'(count), 64'(m_cnt));
        check_eq("full", 64'(full), 64'(m_phase == PH_FULL));
        check_eq("err", 64'(err), 64'(m_err));
        check_eq("done", 64'(done), 64'(m_done));
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic start_step();
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; valid = 1'b0;
        kind = 3'd0; alufunc = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0;
        imm = 16'd0; target = 26'd0;
        @(posedge clk);
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b1, 1'b1, 1'b1, 4, 0, 0, 8, 0, 5, 0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_we", 64'(imem_we), 64'd0);

        // ADDI rs=0 rt=8 imm=5
        start_step();
        step(1'b1, 1'b0, 1'b0, 1'b1, 4, 0, 0, 8, 0, 5, 0);
        check_eq("addi_we", 64'(imem_we), 64'd1);
        check_eq("addi_addr", 64'(imem_addr), 64'd0);
        check_eq("addi_word", 64'(imem_wdata), 64'h2008_0005);
        check_eq("addi_count", 64'(count), 64'd1);

        // RTYPE slt then J back to back, then fill to DEPTH
        start_step();
        step(1'b1, 1'b0, 1'b0, 1'b1, 0, 7, 1, 2, 3, 0, 0);
        check_eq("slt_word", 64'(imem_wdata), 64'h0022_182A);
        check_eq("slt_addr", 64'(imem_addr), 64'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 5, 0, 0, 0, 0, 0, 32'h10);
        check_eq("j_word", 64'(imem_wdata), 64'h0800_0010);
        check_eq("j_addr", 64'(imem_addr), 64'd1);
        check_eq("j_we", 64'(imem_we), 64'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 4, 5, 0, 16'h1234, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 6, 7, 0, 16'hFFFE, 0);
        check_eq("full_flag", 64'(full), 64'd1);
        check_eq("full_count", 64'(count), 64'd4);
        check_eq("full_last_addr", 64'(imem_addr), 64'd3);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4, 0, 1, 1, 0, 1, 0);
        check_eq("full_nowrite", 64'(imem_we), 64'd0);
        check_eq("full_ready", 64'(ready), 64'd0);

        // Illegal kind, then illegal alufunc after restart, then start clears err
        start_step();
        step(1'b1, 1'b0, 1'b0, 1'b1, 4, 0, 1, 1, 0, 1, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 6, 0, 1, 1, 0, 1, 0);
        check_eq("k6_err", 64'(err), 64'd1);
        check_eq("k6_we", 64'(imem_we), 64'd0);
        check_eq("k6_count", 64'(count), 64'd1);
        start_step();
        step(1'b1, 1'b0, 1'b0, 1'b1, 0, 3, 1, 2, 3, 0, 0);
        check_eq("af3_err", 64'(err), 64'd1);
        check_eq("af3_count", 64'(count), 64'd0);
        start_step();
        check_eq("start_clr_err", 64'(err), 64'd0);

        // start with valid, then finish pulse
        step(1'b1, 1'b1, 1'b0, 1'b1, 4, 0, 1, 1, 0, 1, 0);
        check_eq("sv_we", 64'(imem_we), 64'd0);
        check_eq("sv_count", 64'(count), 64'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 4, 0, 1, 1, 0, 1, 0);
        check_eq("fin_done", 64'(done), 64'd1);
        idle_step();
        check_eq("fin_done_off", 64'(done), 64'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("idle_fin_ignored", 64'(done), 64'd0);

        // Reset right after a transfer drops the write
        start_step();
        step(1'b1, 1'b0, 1'b0, 1'b1, 2, 0, 9, 10, 0, 77, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 9, 10, 0, 78, 0);
        check_eq("rst_drop_we", 64'(imem_we), 64'd0);
        check_eq("rst_wdata", 64'(imem_wdata), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) < 8) ? $urandom_range(0, 5) : $urandom_range(6, 7),
                 $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, 256, instruction-memory capacity in words; power of two, at least 2.
REQ-002 Parameter: AW, 8, word-address width; AW SHALL equal log2(DEPTH).
REQ-003 clk_i  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_n_i  in  1  reset, synchronous and active-low.
REQ-005 start_i  in  1  begin a load session: address and count cleared, enter LOAD.
REQ-006 finish_i  in  1  end the load session: LOAD goes to IDLE, done_o pulses.
REQ-007 valid_i  in  1  instruction fields valid.
REQ-008 ready_o  out  1  encoder accepts fields; a transfer occurs when valid_i & ready_o are both high.
REQ-009 kind_i  in  3  instruction kind: 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6-7 illegal.
REQ-010 alufunc_i  in  3  RTYPE operation in ALU-control code: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-011 rs_i, rt_i, rd_i  in  5 each  register fields.
REQ-012 imm_i  in  16  immediate or branch offset; target_i  in  26  jump target.
REQ-013 imem_we_o  out  1  instruction-memory write strobe.
REQ-014 imem_addr_o  out  AW  word address; imem_wdata_o  out  32  encoded instruction.
REQ-015 count_o  out  AW+1  number of words written this session.
REQ-016 full_o  out  1  high in FULL; err_o  out  1  high in ERROR; done_o  out  1  one-cycle session-end pulse.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, FULL and ERROR; ready_o SHALL be high only in LOAD with start_i=0 and finish_i=0.
REQ-018 start_i in any state SHALL, at the next edge, set the write address to 0 and count_o to 0, clear err_o, and enter LOAD; start_i SHALL take priority over finish_i and valid_i.
REQ-019 finish_i in LOAD, FULL or ERROR SHALL enter IDLE and assert done_o for exactly one cycle; finish_i in IDLE SHALL be ignored.
REQ-020 RTYPE SHALL encode as {000000, rs, rt, rd, 00000, funct}, with funct 100000/100010/100100/100101/101010 for alufunc 010/110/000/001/111.
REQ-021 LW, SW, BEQ and ADDI SHALL encode as {op, rs, rt, imm}, with op 100011/101011/000100/001000.
REQ-022 J SHALL encode as {000010, target}.
REQ-023 A transfer at edge N of a legal instruction SHALL drive imem_we_o=1, imem_addr_o=current address and imem_wdata_o=encoded word for exactly the cycle after edge N; latency SHALL be 1 cycle.
REQ-024 On each legal transfer, the address and count_o SHALL increment by 1 at the same edge.
REQ-025 When the transfer writing address DEPTH-1 is accepted, the FSM SHALL enter FULL at that edge and the address SHALL wrap to 0; count_o SHALL read DEPTH.
REQ-026 An illegal transfer (kind 6-7, or RTYPE with an unlisted alufunc) SHALL produce no write, leave the address and count unchanged, and enter ERROR with err_o=1 sticky until start_i or reset.
REQ-027 imem_we_o SHALL be 0 in every cycle not covered by REQ-023; imem_addr_o and imem_wdata_o SHALL hold their last values when the write strobe is low.
REQ-028 Back-to-back transfers SHALL be sustained at one word per cycle.

Reset
REQ-029 rst_n_i=0 at an edge SHALL enter IDLE and zero ready_o, imem_we_o, imem_addr_o, imem_wdata_o, count_o, full_o, err_o and done_o.
REQ-030 Reset SHALL take priority over start_i, finish_i and valid_i.
REQ-031 A reset asserted in the cycle after a transfer SHALL drop the pending write, so imem_we_o is 0 in the following cycle.

Verification
REQ-032 start; transfer ADDI rs=0 rt=8 imm=5 -> next cycle we=1, addr=0, wdata=0x20080005; count_o=1.
REQ-033 Transfer RTYPE alufunc=111 rs=1 rt=2 rd=3, then J target=0x0000010 back-to-back -> wdata 0x0022182A at addr 0, then 0x08000010 at addr 1, in consecutive cycles.
REQ-034 DEPTH=4: four legal transfers -> full_o=1, ready_o=0, count_o=4, address 0; a fifth valid_i produces no write.
REQ-035 Transfer kind=6, then RTYPE alufunc=011 after a restart -> each produces no write and err_o=1 with count unchanged; start_i clears err_o.
REQ-036 start_i and valid_i in the same cycle -> no transfer; state LOAD with count 0; finish_i -> done_o high for exactly one cycle, then IDLE.
REQ-037 Reset in the cycle after a transfer -> imem_we_o=0 next cycle; all outputs 0; state IDLE.
